// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-side transmitter.
// PS2_TX_PARITY_ERR_EN widens FIFO entries to carry a parity-invert flag.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} tx_state_e;

  localparam int FRAME_BITS = 11;
  localparam int STOP_IDX   = 10;

  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam int          ADDR_SEL_BIT = 2;

  localparam int ST_COUNT_W = 5;
  localparam int ST_BUSY    = 5;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 7;

`ifdef PS2_TX_PARITY_ERR_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  // Frame bit i is the i-th bit on the wire: start, data LSB first, parity, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data, input logic inv_par);
    return {1'b1, (~^data) ^ inv_par, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous FIFO with combinational read of the head entry; pushes when
// full and pops when empty are ignored.
module ps2_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // NOTE: state lives in always_ff with non-blocking assignments so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_tx_apb.sv
// APB-programmed PS/2 keyboard emulator: FIFO of scancodes serialised as
// 11-bit frames. Define PS2_TX_PARITY_ERR_EN to allow parity-error injection.
module ps2_kbd_tx_apb
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic        ps2_clk,
  output logic        ps2_data
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FAW     = $clog2(FIFO_DEPTH);

  logic                  r_pready;
  logic                  r_pslverr;
  logic [31:0]           r_prdata;
  logic                  w_access;
  logic                  w_is_status;
  logic                  w_push;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [FAW:0]          w_count;
  logic                  w_busy;
  logic [31:0]           w_status;
  logic                  w_unused;

  tx_state_e             r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [3:0]            r_bit_idx, w_bit_nxt, w_bit_inc;
  logic [FRAME_BITS-1:0] r_frame, w_frame_nxt;
  logic                  r_load, w_load_nxt;
  logic                  r_ps2_clk, w_clk_nxt;
  logic                  r_ps2_data, w_data_nxt;
  logic                  w_inv_par;

  assign w_unused = ^{in_pprot, in_pstrb, in_paddr[31:3], in_paddr[1:0], in_pwdata[31:ENTRY_W]};

  ps2_tx_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .wdata (in_pwdata[ENTRY_W-1:0]),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // APB: one wait state; full is judged on the count before this edge.
  assign w_access    = in_psel & in_penable & ~r_pready;
  assign w_is_status = in_paddr[ADDR_SEL_BIT];
  assign w_push      = w_access & in_pwrite & ~w_is_status & ~w_full;
  assign w_busy      = (r_state != IDLE) | r_load;

  always_comb begin
    w_status                   = '0;
    w_status[ST_COUNT_W-1:0]   = ST_COUNT_W'(w_count);
    w_status[ST_BUSY]          = w_busy;
    w_status[ST_FULL]          = w_full;
    w_status[ST_EMPTY]         = w_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= w_access;
      r_pslverr <= w_access & in_pwrite & (w_is_status | w_full);
      r_prdata  <= (w_access & ~in_pwrite & w_is_status) ? w_status : '0;
    end
  end

`ifdef PS2_TX_PARITY_ERR_EN
  assign w_inv_par = w_head[8];
`else
  assign w_inv_par = 1'b0;
`endif

  assign w_bit_inc = r_bit_idx + 4'd1;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit_idx;
    w_frame_nxt = r_frame;
    w_load_nxt  = 1'b0;
    w_clk_nxt   = r_ps2_clk;
    w_data_nxt  = r_ps2_data;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_load) begin
          w_bit_nxt   = '0;
          w_data_nxt  = r_frame[0];
          w_clk_nxt   = 1'b1;
          w_state_nxt = HIGH;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_load_nxt  = 1'b1;
          w_frame_nxt = build_frame(w_head[7:0], w_inv_par);
        end
      end
      HIGH: begin
        if (r_cnt == CW'(CLK_DIV - 1)) begin
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b0;
          w_state_nxt = LOW;
        end
      end
      LOW: begin
        if (r_cnt == CW'(CLK_DIV - 1)) begin
          w_cnt_nxt = '0;
          w_clk_nxt = 1'b1;
          if (r_bit_idx == 4'(STOP_IDX)) begin
            w_data_nxt  = 1'b1;
            w_state_nxt = GAP;
          end else begin
            w_bit_nxt   = w_bit_inc;
            w_data_nxt  = r_frame[w_bit_inc];
            w_state_nxt = HIGH;
          end
        end
      end
      GAP: begin
        if (r_cnt == CW'(GAP_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_frame    <= '1;
      r_load     <= 1'b0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_frame    <= w_frame_nxt;
      r_load     <= w_load_nxt;
      r_ps2_clk  <= w_clk_nxt;
      r_ps2_data <= w_data_nxt;
    end
  end

  assign in_pready  = r_pready;
  assign in_prdata  = r_prdata;
  assign in_pslverr = r_pslverr;
  assign ps2_clk    = r_ps2_clk;
  assign ps2_data   = r_ps2_data;

endmodule
